// File: rtl/calc_display_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_display_driver_if
// Brief    : Calculator output stream (status/pos/dig/clear) into the display.
// Revision : 1.0
// ============================================================================
interface calc_display_driver_if;
  logic [1:0] status;
  logic [3:0] pos;
  logic [3:0] dig;
  logic       clear;

  modport master (output status, pos, dig, clear);
  modport slave  (input  status, pos, dig, clear);
endinterface
`default_nettype wire

// File: rtl/calc_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : calc_display_driver
// Brief    : Buffers calculator digits and scans them onto an 8-digit 7-seg.
// Revision : 1.0
// ============================================================================
module calc_display_driver #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                        clock,
  input  logic                        reset,
  calc_display_driver_if.slave        calc,
  output logic [7:0]                  an,
  output logic [6:0]                  seg,
  output logic                        dp
);

  localparam int              c_PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_PW-1:0] c_LAST = c_PW'(REFRESH_DIV - 1);

  localparam logic [1:0] c_ERRO    = 2'd0;
  localparam logic [1:0] c_PRONTA  = 2'd1;
  localparam logic [1:0] c_OCUPADA = 2'd2;
  localparam logic [1:0] c_UNDEF   = 2'd3;

  localparam logic [6:0] c_SEG_E     = 7'h06;
  localparam logic [6:0] c_SEG_R     = 7'h2F;
  localparam logic [6:0] c_SEG_DASH  = 7'h3F;
  localparam logic [6:0] c_SEG_BLANK = 7'h7F;

  function automatic logic [6:0] f_digit(input logic [3:0] d);
    logic [6:0] s;
    s = c_SEG_BLANK;
    case (d)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd2: s = 7'h24;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd6: s = 7'h02;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      default: s = c_SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [7:0][3:0] r_buf;
  logic [7:0]      r_valid;
  logic [1:0]      r_status_q;
  logic [c_PW-1:0] r_pcnt;
  logic [2:0]      r_sidx;

  logic            w_wr;
  logic            w_clr;
  logic            w_wrap;
  logic [7:0]      w_an;
  logic [6:0]      w_seg;
  logic            w_dp;

  assign w_wr   = (calc.pos < 4'd8) && (calc.dig < 4'd10);
  // Leaving the error state wipes whatever was captured before the error.
  assign w_clr  = calc.clear || ((r_status_q == c_ERRO) && (calc.status != c_ERRO));
  assign w_wrap = (r_pcnt == c_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_buf      <= '0;
      r_valid    <= '0;
      r_status_q <= c_PRONTA;
    end else begin
      r_status_q <= calc.status;
      if (w_clr) begin
        r_buf   <= '0;
        r_valid <= '0;
      end else if (w_wr) begin
        r_buf[calc.pos[2:0]]   <= calc.dig;
        r_valid[calc.pos[2:0]] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pcnt <= '0;
      r_sidx <= '0;
    end else if (w_wrap) begin
      r_pcnt <= '0;
      r_sidx <= r_sidx + 3'd1;
    end else begin
      r_pcnt <= r_pcnt + c_PW'(1);
    end
  end

  always_comb begin
    w_seg = c_SEG_BLANK;
    case (calc.status)
      c_PRONTA, c_OCUPADA: begin
        if (r_valid[r_sidx]) w_seg = f_digit(r_buf[r_sidx]);
      end
      c_ERRO: begin
        if (r_sidx == 3'd2)      w_seg = c_SEG_E;
        else if (r_sidx < 3'd2)  w_seg = c_SEG_R;
      end
      c_UNDEF: w_seg = c_SEG_DASH;
      default: w_seg = c_SEG_BLANK;
    endcase
    // First cycle of every slot is dark so the previous digit never ghosts.
    w_an = (r_pcnt == '0) ? 8'hFF : ~(8'd1 << r_sidx);
    w_dp = !((calc.status == c_OCUPADA) && (r_sidx == 3'd0));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an  <= 8'hFF;
      seg <= c_SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= w_an;
      seg <= w_seg;
      dp  <= w_dp;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calc_display_driver.sv
`default_nettype none
// Scoreboard bench for calc_display_driver with REFRESH_DIV=4: expectations are
// queued per clock edge after reset release; a monitor pops and compares them.
module tb_calc_display_driver;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  calc_display_driver_if calc();

  calc_display_driver #(.REFRESH_DIV(4)) dut (
    .clock (clock),
    .reset (reset),
    .calc  (calc),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  always #5 clock = ~clock;

  // Rising edges since reset release; outputs after edge E reflect state before E.
  int e = 0;
  always @(posedge clock or negedge reset) begin
    if (!reset) e <= 0;
    else        e <= e + 1;
  end

  typedef struct {
    int         e;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    bit         chk_seg;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input int ev, input logic [7:0] a, input logic [6:0] s,
                      input logic d, input bit cs, input string nm);
    exp_t x;
    x.e = ev; x.an = a; x.seg = s; x.dp = d; x.chk_seg = cs; x.name = nm;
    sb.push_back(x);
  endtask

  // One 32-cycle frame starting at edge fs (fs = 32n+1); seg unchecked in the dark cycle.
  task automatic push_frame(input int fs, input logic [7:0][6:0] segs,
                            input logic [7:0] dps, input string nm);
    int  k;
    bit  g;
    for (int i = 0; i < 32; i++) begin
      k = i / 4;
      g = ((i % 4) == 0);
      push(fs + i, g ? 8'hFF : ~(8'd1 << k), segs[k], dps[k], !g, nm);
    end
  endtask

  task automatic drv(input int at_e, input logic [1:0] st, input logic [3:0] p,
                     input logic [3:0] d, input logic c);
    while (e < at_e) @(negedge clock);
    calc.status = st;
    calc.pos    = p;
    calc.dig    = d;
    calc.clear  = c;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset       = 1'b0;
    calc.status = 2'd1;
    calc.pos    = 4'd15;
    calc.dig    = 4'd0;
    calc.clear  = 1'b0;
    push(0, 8'hFF, 7'h7F, 1'b1, 1'b1, "reset_state");
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
      sb.delete();
    end
    @(negedge clock);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clock);
      #1;
      while (sb.size() > 0 && sb[0].e <= e) begin
        x = sb.pop_front();
        n_cmp++;
        if (x.e != e) begin
          n_bad++;
          $display("FAIL %s: sample for edge %0d missed (now at %0d)", x.name, x.e, e);
        end else if (an !== x.an || dp !== x.dp || (x.chk_seg && seg !== x.seg)) begin
          n_bad++;
          $display("FAIL %s edge %0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b%s",
                   x.name, e, an, seg, dp, x.an, x.seg, x.dp, x.chk_seg ? "" : " (seg ignored)");
        end
      end
    end
  end

  initial begin
    calc.status = 2'd1;
    calc.pos    = 4'd15;
    calc.dig    = 4'd0;
    calc.clear  = 1'b0;

    // Reset, then an empty buffer stays blank.
    do_reset();
    push_frame(1, {8{7'h7F}}, 8'hFF, "reset_blank");
    drain();

    // Full buffer dig=pos+1, then a mid-slot rewrite of slot 1.
    do_reset();
    push_frame(33, {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79}, 8'hFF, "full_frame");
    push(70, 8'hFD, 7'h24, 1'b1, 1'b1, "midslot_old");
    push(71, 8'hFD, 7'h10, 1'b1, 1'b1, "midslot_new");
    push(72, 8'hFD, 7'h10, 1'b1, 1'b1, "midslot_new");
    for (int i = 0; i < 8; i++) drv(i, 2'd1, 4'(i), 4'(i + 1), 1'b0);
    drv(8, 2'd1, 4'd15, 4'd0, 1'b0);
    drv(69, 2'd1, 4'd1, 4'd9, 1'b0);
    drv(70, 2'd1, 4'd15, 4'd0, 1'b0);
    drain();

    // Single write after reset: previous buffer must be gone.
    do_reset();
    push_frame(1,  {{7{7'h7F}}, 7'h12}, 8'hFF, "single_f1");
    push_frame(33, {{7{7'h7F}}, 7'h12}, 8'hFF, "single_f2");
    drv(0, 2'd1, 4'd0, 4'd5, 1'b0);
    drv(1, 2'd1, 4'd15, 4'd0, 1'b0);
    drain();

    // Error override, then leaving ERRO clears the buffer.
    do_reset();
    push_frame(33, {{5{7'h7F}}, 7'h06, 7'h2F, 7'h2F}, 8'hFF, "err_frame");
    push_frame(65, {8{7'h7F}}, 8'hFF, "err_cleared");
    drv(0, 2'd1, 4'd1, 4'd1, 1'b0);
    drv(1, 2'd1, 4'd0, 4'd2, 1'b0);
    drv(2, 2'd0, 4'd15, 4'd0, 1'b0);
    drv(64, 2'd1, 4'd15, 4'd0, 1'b0);
    drain();

    // Busy decimal point on slot 0 only, then gone when ready.
    do_reset();
    push_frame(33, {{7{7'h7F}}, 7'h30}, 8'hFE, "busy_dp");
    push_frame(65, {{7{7'h7F}}, 7'h30}, 8'hFF, "ready_dp");
    drv(0, 2'd2, 4'd0, 4'd3, 1'b0);
    drv(1, 2'd2, 4'd15, 4'd0, 1'b0);
    drv(64, 2'd1, 4'd15, 4'd0, 1'b0);
    drain();

    // Illegal dig/pos ignored, clear beats write, undefined status shows dashes.
    do_reset();
    push_frame(33, {{5{7'h7F}}, 7'h02, 7'h7F, 7'h7F}, 8'hFF, "illegal_prio");
    push_frame(65, {8{7'h3F}}, 8'hFF, "undef_dash");
    drv(0, 2'd1, 4'd3, 4'd12, 1'b0);
    drv(1, 2'd1, 4'd9, 4'd4, 1'b0);
    drv(2, 2'd1, 4'd15, 4'd0, 1'b0);
    drv(3, 2'd1, 4'd0, 4'd7, 1'b1);
    drv(4, 2'd1, 4'd2, 4'd6, 1'b0);
    drv(5, 2'd1, 4'd15, 4'd0, 1'b0);
    drv(64, 2'd3, 4'd15, 4'd0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
